divider_iterative: RTL and testbench



---
 rtl/divider_iterative.sv | 150 +++++++++++++++
 tb/tb_divider_iterative.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_iterative.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// start/ready handshake, synchronous flush and asynchronous reset.
module divider_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startE,
    input  logic            flush,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_divide,
    output logic            ready,
    output logic            busy,
    output logic [1:0]      dbg_state
);
    // Handshake: a start is accepted on a rising edge when the block is IDLE or DONE,
    // startE=1 and flush=0; ready then pulses for exactly one cycle with result_divide valid.
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      opcode_q, opcode_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;

    logic            accept, is_signed, a_neg, b_neg, div_zero, overflow, special;
    logic [XLEN-1:0] a_abs, b_abs, special_result, fix_result, rem_step;
    logic [XLEN:0]   rem_shift, diff;
    logic            take;

    always_comb begin
        accept    = (state_q == S_IDLE || state_q == S_DONE) && startE && !flush;
        is_signed = ~div_opcode[0];
        a_neg     = is_signed & operand1[XLEN-1];
        b_neg     = is_signed & operand2[XLEN-1];
        a_abs     = a_neg ? -operand1 : operand1;
        b_abs     = b_neg ? -operand2 : operand2;
        div_zero  = (operand2 == '0);
        overflow  = is_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
        special   = div_zero | overflow;
        // Overflow quotient equals the dividend itself (most negative value).
        if (div_zero) special_result = div_opcode[1] ? operand1 : '1;
        else          special_result = div_opcode[1] ? '0 : operand1;

        // 33-bit compare: the shifted remainder can exceed XLEN bits for large divisors.
        rem_shift = {rem_q, dvd_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        take      = ~diff[XLEN];
        rem_step  = take ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];

        if (opcode_q[1]) fix_result = r_neg_q ? -rem_q : rem_q;
        else             fix_result = q_neg_q ? -quo_q : quo_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            count_q  <= count_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept)                  state_d = special ? S_DONE : S_CALC;
                else                         state_d = S_IDLE;
            end
            S_CALC: if (count_q == LAST_STEP) state_d = S_FIX;
            S_FIX:                           state_d = S_DONE;
            default:                         state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        opcode_d = opcode_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        count_d  = count_q;
        result_d = result_q;
        if (accept) begin
            opcode_d = div_opcode;
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
            dvd_d    = a_abs;
            dsr_d    = b_abs;
            rem_d    = '0;
            quo_d    = '0;
            count_d  = '0;
            if (special) result_d = special_result;
        end else if (!flush && state_q == S_CALC) begin
            dvd_d   = dvd_q << 1;
            rem_d   = rem_step;
            quo_d   = {quo_q[XLEN-2:0], take};
            count_d = count_q + 1'b1;
        end else if (!flush && state_q == S_FIX) begin
            result_d = fix_result;
        end
    end

    always_comb begin
        ready_d       = (state_d == S_DONE);
        ready         = ready_q;
        busy          = (state_q == S_CALC) || (state_q == S_FIX);
        result_divide = result_q;
        dbg_state     = state_q;
    end
endmodule

// File: tb/tb_divider_iterative.sv
// Directed bench for divider_iterative: vector table for results and latency,
// plus hand sequences for ignored starts, back-to-back ops, reset and flush.
module tb_divider_iterative;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            startE = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      div_opcode = '0;
    logic [XLEN-1:0] operand1 = '0;
    logic [XLEN-1:0] operand2 = '0;
    logic [XLEN-1:0] result_divide;
    logic            ready;
    logic            busy;
    logic [1:0]      dbg_state;

    int total = 0;
    int bad = 0;

    divider_iterative #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .startE(startE), .flush(flush),
        .div_opcode(div_opcode), .operand1(operand1), .operand2(operand2),
        .result_divide(result_divide), .ready(ready), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        startE     = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0;
    endtask

    // Called 1ns after the accepting edge; lat counts further edges until ready is seen.
    task automatic wait_ready(output logic [31:0] res, output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!ready && lat < 100) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result_divide;
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
    endtask

    initial begin
        logic [31:0] res;
        int lat, busy_n, ready_n;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[6]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  0};
        vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          0};
        vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
        vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
        vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          33};
        vecs[11] = '{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  33};
        vecs[12] = '{OP_REMU, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
        vecs[13] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33};
        vecs[14] = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
        vecs[15] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[16] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[17] = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", result_divide, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_state", {30'd0, dbg_state}, 32'd0);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(res, lat, busy_n);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ready_pulse", i), {31'd0, ready}, 32'd0);
        end

        // startE and operand changes during CALC are ignored
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        div_opcode = OP_DIV;
        operand1 = 32'd1000;
        operand2 = 32'd3;
        startE = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0;
        wait_ready(res, lat, busy_n);
        check("ignore_start_result", res, 32'd14);
        check("ignore_start_latency", lat + 11, 33);
        @(posedge clk);
        #1;

        // Back-to-back: new start issued during the DONE cycle
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_ready(res, lat, busy_n);
        check("b2b_first_result", res, 32'd14);
        start_op(OP_REMU, 32'd100, 32'd7);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_ready(res, lat, busy_n);
        check("b2b_second_result", res, 32'd2);
        check("b2b_second_latency", lat, 33);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-calculation
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_state", {30'd0, dbg_state}, 32'd0);
        check("async_rst_ready", {31'd0, ready}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_result", result_divide, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Flush mid-calculation keeps the prior result and never raises ready
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_ready(res, lat, busy_n);
        check("pre_flush_result", res, 32'd14);
        @(posedge clk);
        #1;
        start_op(OP_DIVU, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_state", {30'd0, dbg_state}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        ready_n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) ready_n++;
        end
        check("flush_no_ready", ready_n, 0);
        check("flush_result_kept", result_divide, 32'd14);
        start_op(OP_DIVU, 32'd1000, 32'd3);
        wait_ready(res, lat, busy_n);
        check("post_flush_result", res, 32'd333);
        check("post_flush_latency", lat, 33);
        @(posedge clk);
        #1;

        // flush wins over startE on the same edge
        div_opcode = OP_DIVU;
        operand1 = 32'd50;
        operand2 = 32'd5;
        startE = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0;
        flush = 1'b0;
        check("flush_prio_state", {30'd0, dbg_state}, 32'd0);
        check("flush_prio_busy", {31'd0, busy}, 32'd0);
        check("flush_prio_ready", {31'd0, ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
